cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Fetch/decode/execute sequencer for the simple 4-bit CPU datapath. It fetches 8-bit instructions from program memory over a req/ack handshake and holds the program counter and instruction register. It drives the load enables of the A, B and R registers, the ALU operation select and the operand-source select. It sits between program memory and the datapath register/ALU slice and is the only source of those register enables.

## Interface
Parameters:
- none (widths fixed: 4-bit data/address, 8-bit instruction)

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins execution at address 0
- mem_req  output  1  instruction fetch request; held until ack
- mem_addr  output  4  fetch address (= pc)
- mem_ack  input  1  fetch data valid this cycle
- mem_data  input  8  instruction; [7:4] opcode, [3:0] operand
- r_zero  input  1  datapath R == 4'h0
- imm  output  4  operand field of IR, to datapath source mux
- src_imm  output  1  1 = A/B load from imm; 0 = from R
- a_en  output  1  load enable, A register
- b_en  output  1  load enable, B register
- r_en  output  1  load enable, R register (R <= ALU result)
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
- busy  output  1  high in FETCH/DECODE/EXEC
- halted  output  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. Reset → IDLE.
- IDLE/HALT + start: pc <= 0, go to FETCH. start in any other state is ignored.
- FETCH: mem_req = 1, mem_addr = pc. On a cycle with mem_ack = 1: ir <= mem_data, pc <= pc + 1 (4-bit, 15 wraps to 0), go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. No enables asserted.
- EXEC: one cycle. Enables are asserted per opcode, then the FSM goes to FETCH (or HALT).
- Opcode actions in EXEC:
  - 0 NOP: nothing.
  - 1 LDA: a_en, src_imm = 1.
  - 2 LDB: b_en, src_imm = 1.
  - 3 ADD, 4 SUB, 5 AND, 6 OR: r_en, alu_op = 00/01/10/11.
  - 7 MVA (A <= R): a_en, src_imm = 0.
  - 8 JMP: pc <= imm.
  - 9 JZ: pc <= imm if r_zero, else pc unchanged.
  - F HLT: go to HALT.
  - All other opcodes execute as NOP.
- a_en, b_en and r_en are single-cycle pulses, high only in EXEC. At most one is high at a time.
- alu_op and src_imm are don't-care outside EXEC; they are driven 0.
- imm = ir[3:0] at all times.

## Timing
- Reset (asynchronous, immediate) sets: state IDLE, pc 0, ir 8'h00. Outputs: mem_req 0, a_en/b_en/r_en 0, alu_op 00, src_imm 0, busy 0, halted 0.
- All outputs are Moore-decoded from state and ir. No combinational path from inputs to outputs.
- Per instruction: FETCH lasts N ≥ 1 cycles (N = cycle of the first mem_ack). DECODE 1 cycle, EXEC 1 cycle. Minimum 3 cycles per instruction.
- mem_ack outside FETCH is ignored. mem_data is sampled only when mem_ack = 1 in FETCH.
- Jump target takes effect on the next FETCH. The pc increment from the fetch is overwritten.
- r_zero is sampled in EXEC of JZ. This reflects R after any r_en of the previous instruction.
- Reset asserted during FETCH drops mem_req asynchronously. Any pending ack is discarded.

## Configuration
- CPU_CTRL_JZ_EN defined: opcode 9 is the conditional jump described above.
- CPU_CTRL_JZ_EN undefined:
  - opcode 9 executes as NOP;
  - r_zero is unused;
  - pc is never loaded from imm except by JMP.

## Test plan
- Reset, then start pulse, with mem_ack tied high and program LDA 3, LDB 5, ADD, HLT → in the ADD EXEC cycle r_en = 1 and alu_op = 00. In the LDA EXEC cycle a_en = 1, src_imm = 1, imm = 3. Then halted = 1, busy = 0.
- mem_ack delayed 4 cycles at address 0 → mem_req stays high 5 cycles with mem_addr = 0. ir loads only on the ack cycle. pc = 1 after.
- Program with JMP 2 at address 15 → pc wraps 15 → 0 after the fetch, then is set to 2. The next mem_addr is 2.
- JZ 6 with r_zero = 1 → next fetch at address 6. With r_zero = 0 → next fetch at address pc+1. With CPU_CTRL_JZ_EN undefined → always pc+1.
- rst_n low mid-FETCH with mem_req high → mem_req, busy and pc go to 0 the same cycle, without waiting for a clock edge. A late mem_ack after reset release is ignored. Start pulses while busy are ignored.
- Illegal opcode A → no enable asserted, normal FETCH follows.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns pc/ir and drives datapath enables.
// Define CPU_CTRL_JZ_EN to enable the conditional jump (opcode 9); otherwise it is a NOP.
module cpu_ctrl_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       mem_req,
    output logic [3:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    input  logic       r_zero,
    output logic [3:0] imm,
    output logic       src_imm,
    output logic       a_en,
    output logic       b_en,
    output logic       r_en,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_e;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpLdb = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpAnd = 4'h5;
    localparam logic [3:0] OpOr  = 4'h6;
    localparam logic [3:0] OpMva = 4'h7;
    localparam logic [3:0] OpJmp = 4'h8;
    localparam logic [3:0] OpJz  = 4'h9;
    localparam logic [3:0] OpHlt = 4'hF;

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [3:0] w_opcode;
    logic       w_load_pc;

    assign w_opcode = r_ir[7:4];
    assign imm      = r_ir[3:0];
    assign mem_addr = r_pc;

`ifdef CPU_CTRL_JZ_EN
    assign w_load_pc = (w_opcode == OpJmp) || ((w_opcode == OpJz) && r_zero);
`else
    logic w_unused_r_zero;
    assign w_unused_r_zero = r_zero;
    assign w_load_pc = (w_opcode == OpJmp);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StHalt: if (start) w_state_next = StFetch;
            StFetch:        if (mem_ack) w_state_next = StDecode;
            StDecode:       w_state_next = StExec;
            StExec:         w_state_next = (w_opcode == OpHlt) ? StHalt : StFetch;
            default:        w_state_next = StIdle;
        endcase
    end

    // A jump in EXEC overwrites the increment applied during the preceding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= 4'h0;
            r_ir <= 8'h00;
        end else begin
            unique case (r_state)
                StIdle, StHalt: begin
                    if (start) r_pc <= 4'h0;
                end
                StFetch: begin
                    if (mem_ack) begin
                        r_ir <= mem_data;
                        r_pc <= r_pc + 4'h1;
                    end
                end
                StExec: begin
                    if (w_load_pc) r_pc <= imm;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        a_en    = 1'b0;
        b_en    = 1'b0;
        r_en    = 1'b0;
        alu_op  = 2'b00;
        src_imm = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        unique case (r_state)
            StFetch: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            StDecode: busy = 1'b1;
            StExec: begin
                busy = 1'b1;
                case (w_opcode)
                    OpLda: begin
                        a_en    = 1'b1;
                        src_imm = 1'b1;
                    end
                    OpLdb: begin
                        b_en    = 1'b1;
                        src_imm = 1'b1;
                    end
                    OpAdd: r_en = 1'b1;
                    OpSub: begin
                        r_en   = 1'b1;
                        alu_op = 2'b01;
                    end
                    OpAnd: begin
                        r_en   = 1'b1;
                        alu_op = 2'b10;
                    end
                    OpOr: begin
                        r_en   = 1'b1;
                        alu_op = 2'b11;
                    end
                    OpMva: a_en = 1'b1;
                    default: ;
                endcase
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: per-opcode vector table plus fetch-stall, wrap, reset and
// start-while-busy sequences. Program memory is a small array with a controllable ack.
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       r_zero = 1'b0;
    logic [3:0] imm;
    logic       src_imm, a_en, b_en, r_en, busy, halted;
    logic [1:0] alu_op;

    logic [7:0] prog [16];
    logic       ack_en = 1'b0;
    int         n_run = 0;
    int         n_fail = 0;

    assign mem_data = prog[mem_addr];
    assign mem_ack  = ack_en;

    always #5 clk = ~clk;

    cpu_ctrl_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .r_zero   (r_zero),
        .imm      (imm),
        .src_imm  (src_imm),
        .a_en     (a_en),
        .b_en     (b_en),
        .r_en     (r_en),
        .alu_op   (alu_op),
        .busy     (busy),
        .halted   (halted)
    );

    typedef struct {
        logic [7:0] instr;
        logic       rz;
        logic       a;
        logic       b;
        logic       r;
        logic [1:0] op;
        logic       si;
        logic [3:0] nxt;
        logic       hlt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        ack_en = 1'b0;
        r_zero = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] jz_tgt;
        int cyc, na, nb, nr;
        logic [1:0] r_op;

`ifdef CPU_CTRL_JZ_EN
        jz_tgt = 4'h6;
`else
        jz_tgt = 4'h1;
`endif
        //            instr  rz    a     b     r     op     si    nxt     hlt
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h1,   1'b0};
        vecs[1]  = '{8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'h1,   1'b0};
        vecs[2]  = '{8'h25, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'h1,   1'b0};
        vecs[3]  = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h1,   1'b0};
        vecs[4]  = '{8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 4'h1,   1'b0};
        vecs[5]  = '{8'h52, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 4'h1,   1'b0};
        vecs[6]  = '{8'h63, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 4'h1,   1'b0};
        vecs[7]  = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h1,   1'b0};
        vecs[8]  = '{8'h8C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'hC,   1'b0};
        vecs[9]  = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, jz_tgt, 1'b0};
        vecs[10] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h1,   1'b0};
        vecs[11] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h1,   1'b0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h1,   1'b1};

        // Reset state, checked while rst_n is still low.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        #2;
        chk("reset_outputs", {mem_req, a_en, b_en, r_en, alu_op, src_imm, busy, halted},
            32'h0);
        chk("reset_addr_imm", {mem_addr, imm}, 32'h0);

        // Single-instruction vectors with ack tied high.
        foreach (vecs[k]) begin
            do_reset();
            prog[0] = vecs[k].instr;
            r_zero  = vecs[k].rz;
            ack_en  = 1'b1;
            pulse_start();
            chk($sformatf("v%0d_fetch", k), {mem_req, busy, mem_addr}, {1'b1, 1'b1, 4'h0});
            step();
            chk($sformatf("v%0d_decode", k), {a_en, b_en, r_en, busy}, {3'b000, 1'b1});
            step();
            chk($sformatf("v%0d_exec", k), {a_en, b_en, r_en, alu_op, src_imm, imm, busy},
                {vecs[k].a, vecs[k].b, vecs[k].r, vecs[k].op, vecs[k].si,
                 vecs[k].instr[3:0], 1'b1});
            step();
            chk($sformatf("v%0d_next", k), {mem_addr, halted, busy, mem_req},
                {vecs[k].nxt, vecs[k].hlt, ~vecs[k].hlt, ~vecs[k].hlt});
        end

        // LDA 3, LDB 5, ADD, HLT.
        do_reset();
        prog[0] = 8'h13; prog[1] = 8'h25; prog[2] = 8'h30; prog[3] = 8'hF0;
        ack_en = 1'b1;
        pulse_start();
        cyc = 0; na = 0; nb = 0; nr = 0; r_op = 2'b11;
        while (!halted && cyc < 40) begin
            step();
            cyc++;
            if (a_en) na++;
            if (b_en) nb++;
            if (r_en) begin
                nr++;
                r_op = alu_op;
            end
        end
        chk("prog_cycles_to_halt", cyc, 12);
        chk("prog_enable_counts", {na[7:0], nb[7:0], nr[7:0]}, {8'd1, 8'd1, 8'd1});
        chk("prog_add_aluop", r_op, 2'b00);
        chk("prog_halted", {halted, busy}, 2'b10);

        // Ack delayed 4 cycles at address 0; ir must not load early.
        do_reset();
        prog[0] = 8'h17;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_%0d", i), {mem_req, mem_addr, imm}, {1'b1, 4'h0, 4'h0});
            step();
        end
        chk("stall_last", {mem_req, mem_addr, imm}, {1'b1, 4'h0, 4'h0});
        ack_en = 1'b1;
        step();
        ack_en = 1'b0;
        chk("stall_after_ack", {mem_req, mem_addr, imm}, {1'b0, 4'h1, 4'h7});

        // JMP F at 0, then JMP 2 at 15: pc wraps to 0 after fetch, then becomes 2.
        do_reset();
        prog[0] = 8'h8F; prog[15] = 8'h82;
        ack_en = 1'b1;
        pulse_start();
        step(); step(); step();
        chk("wrap_fetch15", {mem_req, mem_addr}, {1'b1, 4'hF});
        step();
        chk("wrap_pc0", mem_addr, 4'h0);
        step(); step();
        chk("wrap_jmp2", {mem_req, mem_addr}, {1'b1, 4'h2});

        // Asynchronous reset mid-FETCH at address 1, then a late ack is ignored.
        do_reset();
        ack_en = 1'b1;
        pulse_start();
        step(); step(); step();
        ack_en = 1'b0;
        step();
        chk("rst_pre", {mem_req, busy, mem_addr}, {1'b1, 1'b1, 4'h1});
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {mem_req, busy, mem_addr}, {1'b0, 1'b0, 4'h0});
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ack_en = 1'b1;
        step(); step();
        chk("rst_late_ack", {mem_req, busy, mem_addr, imm}, {1'b0, 1'b0, 4'h0, 4'h0});

        // Start during DECODE must not restart at address 0.
        do_reset();
        ack_en = 1'b1;
        pulse_start();
        step();
        pulse_start();
        step();
        chk("start_ignored", {mem_req, mem_addr}, {1'b1, 4'h1});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
